// File: rtl/cla_add_sub_pipe.sv
// Pipelined adder/subtractor: one W-bit carry-lookahead segment per stage, with
// operand skew and result deskew carried in full-width per-stage words.
module cla_add_sub_pipe #(
  parameter int unsigned M      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         cin,
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out,
  output logic         cout,
  output logic         v,
  output logic         zero
);

  localparam int unsigned W = M / STAGES;

  // c holds the carry into this stage's segment on input and its carry-out once
  // registered; cm is the carry into the segment MSB, meaningful for the last stage.
  typedef struct packed {
    logic         vld;
    logic         sub;
    logic         c;
    logic         cm;
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic [M-1:0] r;
  } stage_t;

  stage_t st_q [STAGES];
  stage_t st_d [STAGES];
  stage_t in_s;
  stage_t last;
  logic   en;

  // Returns {carry out, carry into MSB, sum}; lookahead within 4-bit groups,
  // group carries chained from one group to the next.
  function automatic logic [W+1:0] cla_seg(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic         cc;
    logic         pp;
    int unsigned  grp;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = ci;
    for (int unsigned b_i = 0; b_i < W; b_i++) begin
      grp = b_i - (b_i % 4);
      cc  = g[b_i];
      pp  = p[b_i];
      for (int unsigned j = b_i; j > grp; j--) begin
        cc = cc | (pp & g[j-1]);
        pp = pp & p[j-1];
      end
      c[b_i+1] = cc | (pp & c[grp]);
    end
    return {c[W], c[W-1], p ^ c[W-1:0]};
  endfunction

  function automatic stage_t step(input stage_t s, input int unsigned k);
    stage_t         o;
    logic [W+1:0]   seg;
    o   = s;
    seg = cla_seg(s.x[W*k +: W], s.y[W*k +: W], s.c);
    o.r[W*k +: W] = seg[W-1:0];
    o.c  = seg[W+1];
    o.cm = seg[W];
    return o;
  endfunction

  assign last      = st_q[STAGES-1];
  assign out_valid = last.vld;
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out       = last.r;
  assign cout      = last.c ^ last.sub;
  assign v         = last.cm ^ last.c;
  assign zero      = last.vld & ~|last.r;

  always_comb begin
    in_s     = '0;
    in_s.vld = in_valid;
    in_s.sub = sub;
    in_s.c   = sub | cin;
    in_s.x   = x;
    in_s.y   = y ^ {M{sub}};
    st_d[0]  = step(in_s, 0);
    for (int unsigned k = 1; k < STAGES; k++) begin
      st_d[k] = step(st_q[k-1], k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
    end
  end

endmodule

// File: tb/tb_cla_add_sub_pipe.sv
// Directed and handshake-stream checks for cla_add_sub_pipe at M=32, STAGES=4.
module tb_cla_add_sub_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic        cin;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        cout;
  logic        v;
  logic        zero;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cla_add_sub_pipe #(.M(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .cin       (cin),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .v         (v),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {cout, v, zero, out}
  function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sb, input logic ci);
    logic [31:0] ye;
    logic [32:0] s;
    logic        ov;
    ye = sb ? ~b : b;
    s  = {1'b0, a} + {1'b0, ye} + {32'd0, sb | ci};
    ov = (a[31] == ye[31]) && (s[31] != a[31]);
    return {s[32] ^ sb, ov, s[31:0] == 32'd0, s[31:0]};
  endfunction

  task automatic run_one(input string tag, input logic s, input logic ci,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic ec, input logic ev, input logic ez);
    int unsigned lat;
    sub = s; cin = ci; x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_result"}, {out_valid, cout, v, zero, out}, {1'b1, ec, ev, ez, eo});
    tick();
  endtask

  initial begin
    logic [34:0] expq [$];
    logic [34:0] held;
    logic [34:0] e;
    logic        stall_prev;
    logic        saw_valid;
    int unsigned sent;
    int unsigned rcvd;
    int unsigned cyc;

    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; cin = 1'b0;
    x = '0; y = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, cout, v, zero, out}, 64'd0);
    #2 rst_n = 1'b1;
    #1;
    check("ready_after_reset", in_ready, 1);
    tick();

    run_one("add_ovf",     1'b0, 1'b1, 32'h7FFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b1, 1'b0);
    run_one("sub_eq_cin0", 1'b1, 1'b0, 32'd5,        32'd5,        32'h0,        1'b0, 1'b0, 1'b1);
    run_one("sub_eq_cin1", 1'b1, 1'b1, 32'd5,        32'd5,        32'h0,        1'b0, 1'b0, 1'b1);
    run_one("sub_borrow",  1'b1, 1'b0, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    run_one("add_ripple",  1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0, 1'b1);
    run_one("sub_ovf",     1'b1, 1'b0, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_one("add_seg_mix", 1'b0, 1'b1, 32'h00FF00FF, 32'h0F0F0F0F, 32'h100E100F, 1'b0, 1'b0, 1'b0);

    // Random stream with pseudo-random backpressure.
    sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while ((sent < 100 || expq.size() != 0) && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 100) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x = $urandom; y = $urandom;
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) check("stall_stable", {out_valid, cout, v, zero, out}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_beat", out_valid, 0);
        end else begin
          e = expq.pop_front();
          check("stream_beat", {cout, v, zero, out}, e);
          rcvd++;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_model(x, y, sub, cin));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held = {cout, v, zero, out};
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", rcvd, 100);

    // Reset with one result at the output and three beats behind it.
    repeat (4) begin
      x = 32'd11; y = 32'd22; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", {out_valid, cout, v, zero, out}, 64'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("no_stale_after_reset", saw_valid, 0);
    run_one("post_reset", 1'b0, 1'b0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
